motor_ramp_driver: RTL and testbench
====================================

// Module: motor_ramp_driver
// PURPOSE
//  Per-wheel motor stage that sits directly downstream of the car's top-level FSM.
//  Maps the 5-bit FSM state code (mode) to a target duty and direction for each wheel,
//  and slews duty toward that target in fixed ramp steps.
//  A wheel that must reverse is forced through decelerate -> dead-time -> re-drive.
//  Outputs glitch-free PWM and H-bridge direction pins {IN1,IN2} / {IN3,IN4}.
// PARAMETERS
//  PWM_PERIOD   1024    PWM counter period in clk cycles (pwm_cnt runs 0..PWM_PERIOD-1)
//  DUTY_W       11      duty width; must satisfy 2^DUTY_W > PWM_PERIOD
//  DUTY_FAST    768     straight-line duty
//  DUTY_SLOW    384     inner-wheel duty for small corrections and for BACK
//  DUTY_TURN    640     pivot-turn duty
//  RAMP_STEP    32      maximum duty change per ramp tick
//  RAMP_TICKS   100000  clk cycles between ramp ticks
//  DEAD_CYCLES  50000   coast time before a direction reversal
// PORTS
//  clk       in   1      system clock
//  rst       in   1      asynchronous, active-high reset
//  mode      in   5      FSM state code: IDLE=0 START=1 COUNT=2 STRAIGHT=3 CHOOSE=4 LEFT=5
//                        RIGHT=6 BACK=7 LITTLE_LEFT=8 LITTLE_RIGHT=9 STOP=30 ERROR=31
//  pwm       out  2      {left_pwm, right_pwm}
//  l_IN      out  2      left bridge pins: FWD=2'b10, REV=2'b01, coast=2'b00
//  r_IN      out  2      right bridge pins, same encoding as l_IN
//  at_speed  out  1      both wheels in RUN, direction matches target, duty==target, applied==duty
// BEHAVIOUR
//  Reset (all registers cleared, async)
//   - pwm=0, l_IN=r_IN=00, at_speed=0.
//   - duty=0, applied duty=0, pwm_cnt=0, tick_cnt=0.
//   - Each wheel: state=RUN, dir=FWD.
//  Target table (left / right), all directions forward unless marked R
//   - 0,1,2,30, and undefined codes other than 31: 0 / 0.
//   - 3,4: FAST / FAST.   8: SLOW / FAST.   9: FAST / SLOW.
//   - 5: TURN R / TURN.   6: TURN / TURN R.   7: SLOW R / SLOW R.
//  Ramp tick
//   - tick_cnt counts 0..RAMP_TICKS-1; tick pulses for one cycle on wrap.
//   - tick_cnt free-runs and is not reset by mode changes.
//   - On a tick, duty moves toward the effective target by min(RAMP_STEP, |target-duty|).
//   - No overshoot; no change between ticks.
//  Per-wheel FSM, evaluated every cycle
//   - RUN:
//     - desired dir != dir and duty>0 -> DECEL.
//     - desired dir != dir and duty==0 -> DEAD, load dead counter.
//   - DECEL:
//     - Effective target = 0 and ramps down on ticks.
//     - desired dir returns to dir -> RUN immediately, no dead time.
//     - duty==0 -> DEAD.
//   - DEAD:
//     - Bridge pins 00; count DEAD_CYCLES clk cycles.
//     - At expiry: dir <= desired dir sampled that cycle, then -> RUN.
//     - Ramp-up starts from the next tick.
//  Applied duty
//   - Copied from duty only when pwm_cnt==0, so a period never sees a duty change.
//   - pwm is registered: pwm_x <= (pwm_cnt < applied_x).
//   - applied==PWM_PERIOD gives constant 1; applied==0 gives constant 0.
//  Bridge pins
//   - Driven to dir encoding in RUN/DECEL.
//   - Forced to 00 in DEAD, and in RUN when applied==0 and target==0.
//  ERROR (31) override
//   - Next clk: duty=applied=0, pwm=0, pins=00, both wheels RUN with dir held.
//   - Bypasses the ramp and the period boundary.
//   - Leaving ERROR: normal ramp-up from 0.
//  Mode change mid-ramp
//   - The new target takes effect the next cycle; the ramp continues from the current duty.
//  at_speed: registered, 1-cycle latency.
// TESTING
//  Sim params for all tests: PWM_PERIOD=16, RAMP_TICKS=4, RAMP_STEP=4, DEAD_CYCLES=8,
//  FAST=12, SLOW=4, TURN=8.
//  T1 mode 0->3: duty 0,4,8,12 on successive ticks (4 clk apart).
//     -> pwm high 12/16 once settled; l_IN=r_IN=10; at_speed=1.
//  T2 3->5 at FAST: left ramps 12->0, pins 00 for 8 clk, l_IN=01, ramps to 8.
//     -> right ramps 12->8 with no dead time.
//  T3 3 at FAST, then 31 -> next clk pwm=00, pins 00, duty 0.
//     -> back to 3: ramp-up restarts from 0.
//  T4 5->6 mid-DECEL of left (duty 8->4): left desired FWD == dir.
//     -> left returns to RUN, ramps 4->8, no DEAD.
//  T5 change duty mid-period (pwm_cnt=5) -> current period keeps the old width.
//     -> new width applies from pwm_cnt==0.
//  T6 assert rst during DEAD -> next edge pwm=0, pins 00, both RUN/FWD, duty 0.

Source files
------------

// File: rtl/motor_ramp_driver.sv
// motor_ramp_driver
//   Per-wheel motor stage that follows the car's top-level FSM. The 5-bit FSM
//   state code selects a target duty and direction for each wheel. Duty slews
//   toward that target in bounded steps on a slow ramp tick. A wheel that has
//   to reverse first ramps to zero, then coasts for a dead time, then re-drives.
//   PWM and H-bridge pins are registered, so they do not glitch.
//
// Ports
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   mode      in   [4:0] FSM state code (31 = ERROR, forces an immediate stop)
//   pwm       out  [1:0] {left_pwm, right_pwm}
//   l_IN      out  [1:0] left bridge pins: FWD=10, REV=01, coast=00
//   r_IN      out  [1:0] right bridge pins, same encoding
//   at_speed  out  both wheels settled on their target (one cycle latency)

// motor_ramp_wheel
//   Ramp, reversal FSM, applied-duty latch and PWM/pin registers for one wheel.
// Ports
//   clk, rst     clock / async active-high reset
//   err_i        ERROR override: zero duty, PWM and pins on the next edge
//   tick_i       one-cycle ramp tick
//   pwm_cnt_i    shared PWM period counter
//   tgt_duty_i   target duty from the mode table
//   tgt_rev_i    desired direction (1 = reverse)
//   pwm_o        registered PWM output
//   pins_o       registered bridge pins
//   at_tgt_o     wheel settled (RUN, direction, duty and applied duty match)
module motor_ramp_wheel #(
    parameter int PWM_PERIOD  = 1024,
    parameter int DUTY_W      = 11,
    parameter int RAMP_STEP   = 32,
    parameter int DEAD_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              err_i,
    input  logic              tick_i,
    input  logic [DUTY_W-1:0] pwm_cnt_i,
    input  logic [DUTY_W-1:0] tgt_duty_i,
    input  logic              tgt_rev_i,
    output logic              pwm_o,
    output logic [1:0]        pins_o,
    output logic              at_tgt_o
);
    localparam int                DCW       = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
    localparam logic [DCW-1:0]    DEAD_LOAD = DCW'(DEAD_CYCLES - 1);
    localparam logic [DUTY_W-1:0] STEP      = DUTY_W'(RAMP_STEP);

    typedef enum logic [1:0] {RUN, DECEL, DEAD} wstate_t;

    wstate_t           state_q, state_d;
    logic              dir_q, dir_d;          // 1 = reverse
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] applied_q, applied_d;
    logic [DCW-1:0]    dead_q, dead_d;
    logic              pwm_q, pwm_d;
    logic [1:0]        pins_q, pins_d;
    logic [DUTY_W-1:0] eff;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            dir_q     <= 1'b0;
            duty_q    <= '0;
            applied_q <= '0;
            dead_q    <= '0;
            pwm_q     <= 1'b0;
            pins_q    <= 2'b00;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            duty_q    <= duty_d;
            applied_q <= applied_d;
            dead_q    <= dead_d;
            pwm_q     <= pwm_d;
            pins_q    <= pins_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        duty_d    = duty_q;
        applied_d = applied_q;
        dead_d    = dead_q;
        pwm_d     = 1'b0;
        pins_d    = 2'b00;
        eff       = '0;
        if (err_i) begin
            // Hard stop: skip the ramp and the period boundary, keep direction.
            duty_d    = '0;
            applied_d = '0;
            state_d   = RUN;
        end else begin
            // Never accelerate while the wheel still points the wrong way.
            if (state_q != DEAD && tgt_rev_i == dir_q) eff = tgt_duty_i;

            if (tick_i) begin
                if (duty_q < eff)
                    duty_d = (eff - duty_q > STEP) ? duty_q + STEP : eff;
                else if (duty_q > eff)
                    duty_d = (duty_q - eff > STEP) ? duty_q - STEP : eff;
            end

            case (state_q)
                RUN: begin
                    if (tgt_rev_i != dir_q) begin
                        if (duty_q != '0) begin
                            state_d = DECEL;
                        end else begin
                            state_d = DEAD;
                            dead_d  = DEAD_LOAD;
                        end
                    end
                end
                DECEL: begin
                    if (tgt_rev_i == dir_q) begin
                        state_d = RUN;
                    end else if (duty_q == '0) begin
                        state_d = DEAD;
                        dead_d  = DEAD_LOAD;
                    end
                end
                DEAD: begin
                    if (dead_q == '0) begin
                        state_d = RUN;
                        dir_d   = tgt_rev_i;
                    end else begin
                        dead_d = dead_q - DCW'(1);
                    end
                end
                default: state_d = RUN;
            endcase

            // Latch at the period start so a period never sees a width change.
            if (pwm_cnt_i == '0) applied_d = duty_q;
            pwm_d = (pwm_cnt_i < applied_d);

            if (state_d == DEAD || (state_d == RUN && applied_d == '0 && tgt_duty_i == '0))
                pins_d = 2'b00;
            else
                pins_d = dir_d ? 2'b01 : 2'b10;
        end
    end

    assign pwm_o    = pwm_q;
    assign pins_o   = pins_q;
    assign at_tgt_o = (state_q == RUN) && (dir_q == tgt_rev_i) &&
                      (duty_q == tgt_duty_i) && (applied_q == duty_q);
endmodule

module motor_ramp_driver #(
    parameter int PWM_PERIOD  = 1024,
    parameter int DUTY_W      = 11,
    parameter int DUTY_FAST   = 768,
    parameter int DUTY_SLOW   = 384,
    parameter int DUTY_TURN   = 640,
    parameter int RAMP_STEP   = 32,
    parameter int RAMP_TICKS  = 100000,
    parameter int DEAD_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] mode,
    output logic [1:0] pwm,
    output logic [1:0] l_IN,
    output logic [1:0] r_IN,
    output logic       at_speed
);
    localparam int                TW    = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [DUTY_W-1:0] FAST  = DUTY_W'(DUTY_FAST);
    localparam logic [DUTY_W-1:0] SLOW  = DUTY_W'(DUTY_SLOW);
    localparam logic [DUTY_W-1:0] TURN  = DUTY_W'(DUTY_TURN);
    localparam logic [DUTY_W-1:0] P_MAX = DUTY_W'(PWM_PERIOD - 1);
    localparam logic [TW-1:0]     T_MAX = TW'(RAMP_TICKS - 1);

    logic [TW-1:0]          tick_q;
    logic [DUTY_W-1:0]      pwm_cnt_q;
    logic                   at_speed_q;
    logic                   tick, err;
    // Index 1 = left wheel, 0 = right wheel, matching pwm = {left, right}.
    logic [1:0][DUTY_W-1:0] tgt_duty;
    logic [1:0]             tgt_rev;
    logic [1:0]             wheel_pwm;
    logic [1:0][1:0]        wheel_pins;
    logic [1:0]             wheel_at;

    assign tick = (tick_q == T_MAX);
    assign err  = (mode == 5'd31);

    // Free-running timers; mode changes never disturb them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q     <= '0;
            pwm_cnt_q  <= '0;
            at_speed_q <= 1'b0;
        end else begin
            tick_q     <= tick ? '0 : tick_q + TW'(1);
            pwm_cnt_q  <= (pwm_cnt_q == P_MAX) ? '0 : pwm_cnt_q + DUTY_W'(1);
            at_speed_q <= &wheel_at;
        end
    end

    always_comb begin
        tgt_duty = '0;
        tgt_rev  = 2'b00;
        case (mode)
            5'd3, 5'd4: tgt_duty = {FAST, FAST};
            5'd5: begin tgt_duty = {TURN, TURN}; tgt_rev = 2'b10; end
            5'd6: begin tgt_duty = {TURN, TURN}; tgt_rev = 2'b01; end
            5'd7: begin tgt_duty = {SLOW, SLOW}; tgt_rev = 2'b11; end
            5'd8: tgt_duty = {SLOW, FAST};
            5'd9: tgt_duty = {FAST, SLOW};
            default: ;
        endcase
    end

    for (genvar w = 0; w < 2; w++) begin : g_wheel
        motor_ramp_wheel #(
            .PWM_PERIOD (PWM_PERIOD),
            .DUTY_W     (DUTY_W),
            .RAMP_STEP  (RAMP_STEP),
            .DEAD_CYCLES(DEAD_CYCLES)
        ) u_wheel (
            .clk       (clk),
            .rst       (rst),
            .err_i     (err),
            .tick_i    (tick),
            .pwm_cnt_i (pwm_cnt_q),
            .tgt_duty_i(tgt_duty[w]),
            .tgt_rev_i (tgt_rev[w]),
            .pwm_o     (wheel_pwm[w]),
            .pins_o    (wheel_pins[w]),
            .at_tgt_o  (wheel_at[w])
        );
    end

    assign pwm      = wheel_pwm;
    assign l_IN     = wheel_pins[1];
    assign r_IN     = wheel_pins[0];
    assign at_speed = at_speed_q;
endmodule

// File: tb/tb_motor_ramp_driver.sv
// Bench for motor_ramp_driver with small timing parameters. A behavioural
// model of the wheel rules (target table, bounded ramp, reversal with dead
// time, period-aligned duty latch) predicts every output each cycle.
module tb_motor_ramp_driver;
    localparam int P = 16, DW = 5, FAST = 12, SLOW = 4, TURN = 8;
    localparam int RS = 4, RT = 4, DC = 8;
    localparam int S_RUN = 0, S_DECEL = 1, S_DEAD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] mode = 5'd0;
    logic [1:0] pwm, l_IN, r_IN;
    logic       at_speed;

    int checks = 0;
    int errors = 0;

    // Model state; index 0 = left wheel, 1 = right wheel.
    int m_tk, m_pc, m_at;
    int m_st[2], m_dir[2], m_duty[2], m_app[2], m_dc[2], m_pwm[2], m_pins[2];

    motor_ramp_driver #(
        .PWM_PERIOD(P), .DUTY_W(DW), .DUTY_FAST(FAST), .DUTY_SLOW(SLOW),
        .DUTY_TURN(TURN), .RAMP_STEP(RS), .RAMP_TICKS(RT), .DEAD_CYCLES(DC)
    ) dut (
        .clk(clk), .rst(rst), .mode(mode), .pwm(pwm),
        .l_IN(l_IN), .r_IN(r_IN), .at_speed(at_speed)
    );

    always #5 clk = ~clk;

    task automatic get_target(input logic [4:0] md, output int tl, output int rl,
                              output int tr, output int rr);
        tl = 0; rl = 0; tr = 0; rr = 0;
        case (md)
            5'd3, 5'd4: begin tl = FAST; tr = FAST; end
            5'd5: begin tl = TURN; rl = 1; tr = TURN; end
            5'd6: begin tl = TURN; tr = TURN; rr = 1; end
            5'd7: begin tl = SLOW; rl = 1; tr = SLOW; rr = 1; end
            5'd8: begin tl = SLOW; tr = FAST; end
            5'd9: begin tl = FAST; tr = SLOW; end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_tk = 0; m_pc = 0; m_at = 0;
        for (int w = 0; w < 2; w++) begin
            m_st[w] = S_RUN; m_dir[w] = 0; m_duty[w] = 0; m_app[w] = 0;
            m_dc[w] = 0; m_pwm[w] = 0; m_pins[w] = 0;
        end
    endtask

    // One clock edge of the intended behaviour, from pre-edge state and mode.
    task automatic model_step();
        int tg[2], rv[2];
        int tl, rl, tr, rr, eff, at;
        int n_st, n_dir, n_duty, n_app, n_dc;
        bit tick, err;
        get_target(mode, tl, rl, tr, rr);
        tg[0] = tl; rv[0] = rl; tg[1] = tr; rv[1] = rr;
        err  = (mode == 5'd31);
        tick = (m_tk == RT - 1);
        at   = 1;
        for (int w = 0; w < 2; w++)
            if (!(m_st[w] == S_RUN && m_dir[w] == rv[w] && m_duty[w] == tg[w] && m_app[w] == m_duty[w]))
                at = 0;
        for (int w = 0; w < 2; w++) begin
            n_st = m_st[w]; n_dir = m_dir[w]; n_duty = m_duty[w]; n_app = m_app[w]; n_dc = m_dc[w];
            if (err) begin
                n_duty = 0; n_app = 0; n_st = S_RUN;
                m_pwm[w] = 0; m_pins[w] = 0;
            end else begin
                eff = (m_st[w] != S_DEAD && rv[w] == m_dir[w]) ? tg[w] : 0;
                if (tick) begin
                    if (m_duty[w] < eff) n_duty = (m_duty[w] + RS > eff) ? eff : m_duty[w] + RS;
                    else n_duty = (m_duty[w] - RS < eff) ? eff : m_duty[w] - RS;
                end
                if (m_st[w] == S_RUN && rv[w] != m_dir[w]) begin
                    if (m_duty[w] > 0) n_st = S_DECEL;
                    else begin n_st = S_DEAD; n_dc = DC - 1; end
                end else if (m_st[w] == S_DECEL) begin
                    if (rv[w] == m_dir[w]) n_st = S_RUN;
                    else if (m_duty[w] == 0) begin n_st = S_DEAD; n_dc = DC - 1; end
                end else if (m_st[w] == S_DEAD) begin
                    if (m_dc[w] == 0) begin n_st = S_RUN; n_dir = rv[w]; end
                    else n_dc = m_dc[w] - 1;
                end
                if (m_pc == 0) n_app = m_duty[w];
                m_pwm[w] = (m_pc < n_app) ? 1 : 0;
                if (n_st == S_DEAD || (n_st == S_RUN && n_app == 0 && tg[w] == 0)) m_pins[w] = 0;
                else m_pins[w] = n_dir ? 1 : 2;
            end
            m_st[w] = n_st; m_dir[w] = n_dir; m_duty[w] = n_duty; m_app[w] = n_app; m_dc[w] = n_dc;
        end
        m_at = at;
        m_tk = tick ? 0 : m_tk + 1;
        m_pc = (m_pc + 1) % P;
    endtask

    function automatic logic [6:0] model_vec();
        return {1'(m_pwm[0]), 1'(m_pwm[1]), 2'(m_pins[0]), 2'(m_pins[1]), 1'(m_at)};
    endfunction

    // Advance one clock; outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pwm, l_IN, r_IN, at_speed} !== 7'b0) begin
            errors++; $display("FAIL reset_state got %b exp 0000000", {pwm, l_IN, r_IN, at_speed});
        end
        model_reset();
        rst = 1'b0;
        repeat (6) begin
            cyc();
            checks++;
            if ({pwm, l_IN, r_IN, at_speed} !== model_vec()) begin
                errors++; $display("FAIL reset_idle got %b exp %b", {pwm, l_IN, r_IN, at_speed}, model_vec());
            end
        end
    endtask

    // 0 -> 3: both wheels ramp 0,4,8,12 and settle at 12/16 forward.
    task automatic test_ramp_up();
        int hl, hr;
        mode = 5'd3;
        repeat (40) begin
            cyc();
            checks++;
            if ({pwm, l_IN, r_IN, at_speed} !== model_vec()) begin
                errors++; $display("FAIL ramp_up got %b exp %b", {pwm, l_IN, r_IN, at_speed}, model_vec());
            end
        end
        hl = 0; hr = 0;
        repeat (P) begin
            cyc();
            hl += int'(pwm[1]); hr += int'(pwm[0]);
        end
        checks++;
        if (hl != FAST || hr != FAST) begin
            errors++; $display("FAIL ramp_up_width got %0d/%0d exp %0d/%0d", hl, hr, FAST, FAST);
        end
        checks++;
        if ({l_IN, r_IN, at_speed} !== 5'b10101) begin
            errors++; $display("FAIL ramp_up_pins got %b exp 10101", {l_IN, r_IN, at_speed});
        end
    endtask

    // 3 -> 5: left decelerates, coasts exactly DC cycles, drives reverse to TURN.
    task automatic test_reverse();
        int lz, rz;
        mode = 5'd5;
        lz = 0; rz = 0;
        repeat (100) begin
            cyc();
            if (l_IN == 2'b00) lz++;
            if (r_IN == 2'b00) rz++;
            checks++;
            if ({pwm, l_IN, r_IN, at_speed} !== model_vec()) begin
                errors++; $display("FAIL reverse got %b exp %b", {pwm, l_IN, r_IN, at_speed}, model_vec());
            end
        end
        checks++;
        if (lz != DC || rz != 0) begin
            errors++; $display("FAIL reverse_dead got left=%0d right=%0d exp %0d/0", lz, rz, DC);
        end
        checks++;
        if ({l_IN, r_IN, at_speed} !== 5'b01101) begin
            errors++; $display("FAIL reverse_pins got %b exp 01101", {l_IN, r_IN, at_speed});
        end
    endtask

    // ERROR stops everything on the next edge; leaving it ramps from zero.
    task automatic test_error();
        mode = 5'd3;
        repeat (80) cyc();
        mode = 5'd31;
        cyc();
        checks++;
        if ({pwm, l_IN, r_IN} !== 6'b0) begin
            errors++; $display("FAIL error_stop got %b exp 000000", {pwm, l_IN, r_IN});
        end
        repeat (5) begin
            cyc();
            checks++;
            if ({pwm, l_IN, r_IN, at_speed} !== model_vec()) begin
                errors++; $display("FAIL error_hold got %b exp %b", {pwm, l_IN, r_IN, at_speed}, model_vec());
            end
        end
        mode = 5'd3;
        cyc();
        checks++;
        if (pwm !== 2'b00) begin
            errors++; $display("FAIL error_exit_pwm got %b exp 00", pwm);
        end
        repeat (50) begin
            cyc();
            checks++;
            if ({pwm, l_IN, r_IN, at_speed} !== model_vec()) begin
                errors++; $display("FAIL error_exit got %b exp %b", {pwm, l_IN, r_IN, at_speed}, model_vec());
            end
        end
    endtask

    // Left in DECEL (8 -> 4) when the direction request flips back: no dead time.
    task automatic test_decel_abort();
        int lz, n;
        mode = 5'd6;
        repeat (100) cyc();
        mode = 5'd5;
        lz = 0; n = 0;
        while (m_duty[0] != 4 && n < 20) begin
            cyc(); n++;
            if (l_IN == 2'b00) lz++;
        end
        checks++;
        if (n >= 20) begin
            errors++; $display("FAIL decel_abort_timeout got duty=%0d exp 4", m_duty[0]);
        end
        mode = 5'd6;
        repeat (50) begin
            cyc();
            if (l_IN == 2'b00) lz++;
            checks++;
            if ({pwm, l_IN, r_IN, at_speed} !== model_vec()) begin
                errors++; $display("FAIL decel_abort got %b exp %b", {pwm, l_IN, r_IN, at_speed}, model_vec());
            end
        end
        checks++;
        if (lz != 0 || l_IN !== 2'b10) begin
            errors++; $display("FAIL decel_abort_dead got zeros=%0d pins=%b exp 0/10", lz, l_IN);
        end
    endtask

    // Target change at pwm_cnt==5: rest of the period keeps width 12.
    task automatic test_midperiod();
        int hr, n;
        mode = 5'd3;
        repeat (80) cyc();
        n = 0;
        while (m_pc != 5 && n < 2 * P) begin cyc(); n++; end
        mode = 5'd9;
        hr = 0;
        repeat (P - 5) begin
            cyc();
            hr += int'(pwm[0]);
        end
        checks++;
        if (hr != FAST - 5) begin
            errors++; $display("FAIL midperiod_width got %0d exp %0d", hr, FAST - 5);
        end
        repeat (40) begin
            cyc();
            checks++;
            if ({pwm, l_IN, r_IN, at_speed} !== model_vec()) begin
                errors++; $display("FAIL midperiod got %b exp %b", {pwm, l_IN, r_IN, at_speed}, model_vec());
            end
        end
    endtask

    // Reset while both wheels sit in DEAD.
    task automatic test_rst_dead();
        int n;
        mode = 5'd3;
        repeat (60) cyc();
        mode = 5'd7;
        n = 0;
        while (m_st[0] != S_DEAD && n < 40) begin cyc(); n++; end
        checks++;
        if (n >= 40) begin
            errors++; $display("FAIL rst_dead_timeout got state=%0d exp %0d", m_st[0], S_DEAD);
        end
        repeat (2) cyc();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({pwm, l_IN, r_IN, at_speed} !== 7'b0) begin
            errors++; $display("FAIL rst_dead_async got %b exp 0000000", {pwm, l_IN, r_IN, at_speed});
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (40) begin
            cyc();
            checks++;
            if ({pwm, l_IN, r_IN, at_speed} !== model_vec()) begin
                errors++; $display("FAIL rst_dead_after got %b exp %b", {pwm, l_IN, r_IN, at_speed}, model_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 30; seg++) begin
            if ($urandom_range(0, 3) == 0) mode = 5'($urandom_range(0, 31));
            else mode = 5'($urandom_range(3, 9));
            repeat ($urandom_range(1, 40)) begin
                cyc();
                checks++;
                if ({pwm, l_IN, r_IN, at_speed} !== model_vec()) begin
                    errors++; $display("FAIL random mode=%0d got %b exp %b", mode, {pwm, l_IN, r_IN, at_speed}, model_vec());
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_ramp_up();
        test_reverse();
        test_error();
        test_decel_abort();
        test_midperiod();
        test_rst_dead();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
